// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   - access size codes for the data port
//   - arbiter FSM state encoding
//   - grant identifiers for the two requesters
//   - alignment/legality check for data-port accesses
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_WR   = 2'd3
    } state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // 1 when a data access can't be performed: misaligned half/word or the
    // reserved size code.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = off[0];
            SZ_W:    err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter between the RAM word and the data port.
//   rword_i  : word read from RAM
//   off_i    : byte offset within the word (address bits [1:0])
//   size_i   : access size code
//   sext_i   : sign-extend sub-word loads
//   wdata_i  : right-aligned store data
//   load_o   : extracted and extended load result
//   merge_o  : rword_i with the addressed lanes replaced by store data
//              (full wdata_i for word accesses)
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rword_i[{off_i, 3'b000} +: 8];
        half_v  = off_i[1] ? rword_i[31:16] : rword_i[15:0];
        load_o  = rword_i;
        merge_o = rword_i;
        case (size_i)
            SZ_B: begin
                load_o = {{24{sext_i & byte_v[7]}}, byte_v};
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                load_o = {{16{sext_i & half_v[15]}}, half_v};
                if (off_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            default: begin
                // Word: no extension, whole word replaced.
                load_o  = rword_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port (i_*) and
// the load/store port (d_*). Round-robin arbitration in IDLE, sub-word
// stores done as read-modify-write, loads lane-extracted and extended.
//   clk, rst           : clock, synchronous active-high reset
//   i_req/i_addr       : fetch request (word-aligned, addr[1:0] ignored)
//   i_ready            : fetch accepted this cycle
//   i_valid/i_rdata    : fetched word, one-cycle pulse
//   d_req/d_we/d_addr/d_size/d_sext/d_wdata : data request
//   d_ready            : data request accepted this cycle
//   d_valid/d_rdata/d_err : completion pulse, load data, error flag
//   m_addr/m_we/m_wdata/m_rdata : RAM interface (read data 1 cycle late)
//   dbg_state          : current FSM state
//
// Handshake: a requester holds req and its fields stable until it sees
// ready high in a cycle; that cycle is the accept. Exactly one ready can be
// high in a cycle and only in IDLE. Completion is a one-cycle valid pulse.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_valid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_size,
    input  logic              d_sext,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-3:0] m_addr,
    output logic              m_we,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic [1:0]        dbg_state
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic              i_valid_q, i_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              d_err_q, d_err_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;

    logic              gnt;
    logic              any_req;
    logic              d_is_err;
    logic [31:0]       fmt_load;
    logic [31:0]       fmt_merge;

    mem_lane_fmt u_lane_fmt (
        .rword_i (m_rdata),
        .off_i   (addr_q[1:0]),
        .size_i  (size_q),
        .sext_i  (sext_q),
        .wdata_i (wdata_q),
        .load_o  (fmt_load),
        .merge_o (fmt_merge)
    );

    // Round-robin: on contention the port that did not win last time wins.
    always_comb begin
        any_req  = i_req | d_req;
        d_is_err = access_err(d_size, d_addr[1:0]);
        if (i_req && d_req) begin
            gnt = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
        end else begin
            gnt = d_req ? GNT_D : GNT_I;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        size_d       = size_q;
        sext_d       = sext_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mwdata_d     = mwdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_valid_d    = 1'b0;
        d_valid_d    = 1'b0;
        d_err_d      = 1'b0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req && !rst) begin
                    last_grant_d = gnt;
                    port_d       = gnt;
                    if (gnt == GNT_I) begin
                        i_ready = 1'b1;
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        size_d  = SZ_W;
                        sext_d  = 1'b0;
                        state_d = ST_RD;
                    end else begin
                        d_ready = 1'b1;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        size_d  = d_size;
                        sext_d  = d_sext;
                        if (d_is_err) begin
                            // Rejected without touching the RAM.
                            d_valid_d = 1'b1;
                            d_err_d   = 1'b1;
                        end else if (d_we && d_size == SZ_W) begin
                            mwdata_d = d_wdata;
                            state_d  = ST_WR;
                        end else begin
                            // Loads and sub-word stores both read first.
                            wdata_d = d_wdata;
                            state_d = ST_RD;
                        end
                    end
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (port_q == GNT_I) begin
                    i_rdata_d = m_rdata;
                    i_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (we_q) begin
                    mwdata_d = fmt_merge;
                    state_d  = ST_WR;
                end else begin
                    d_rdata_d = fmt_load;
                    d_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR: begin
                d_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_I;
            port_q       <= GNT_I;
            we_q         <= 1'b0;
            size_q       <= SZ_W;
            sext_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mwdata_q     <= '0;
            i_valid_q    <= 1'b0;
            d_valid_q    <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mwdata_q     <= mwdata_d;
            i_valid_q    <= i_valid_d;
            d_valid_q    <= d_valid_d;
            d_err_q      <= d_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // The RAM address simply follows the captured request; writes only
    // happen in WR, and never while reset is held.
    assign m_addr    = addr_q[ADDR_W-1:2];
    assign m_we      = (state_q == ST_WR) && !rst;
    assign m_wdata   = mwdata_q;
    assign i_valid   = i_valid_q;
    assign i_rdata   = i_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ready, i_valid;
    logic [31:0]       i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [1:0]        d_size = 2'b00;
    logic              d_sext = 1'b0;
    logic [31:0]       d_wdata = '0;
    logic              d_ready, d_valid, d_err;
    logic [31:0]       d_rdata;
    logic [ADDR_W-3:0] m_addr;
    logic              m_we;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata = '0;
    logic [1:0]        dbg_state;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_sext(d_sext),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .dbg_state(dbg_state)
    );

    // clock / RAM model
    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_wdata;
        m_rdata <= mem[m_addr];
    end

    // scoreboard state
    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int dv_cnt  = 0;
    logic [33:0] exp_d_q[$];   // {check_data, err, rdata}
    logic [31:0] exp_i_q[$];
    logic [31:0] last_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_we) we_cnt++;
            if (d_valid) begin
                logic [33:0] e;
                dv_cnt++;
                if (exp_d_q.size() == 0) begin
                    chk("unexpected d_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_d_q.pop_front();
                    chk("d_err", {31'd0, d_err}, {31'd0, e[32]});
                    if (e[33]) chk("d_rdata", d_rdata, e[31:0]);
                end
            end
            if (i_valid) begin
                if (exp_i_q.size() == 0) begin
                    chk("unexpected i_valid", 32'd1, 32'd0);
                end else begin
                    chk("i_rdata", i_rdata, exp_i_q.pop_front());
                end
            end
        end
    end

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] exp_data;  // load result, or RAM word after a store
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[20];

    // driver tasks
    task automatic do_d(input vec_t v);
        logic [33:0] e;
        logic        acc;
        int          lat;
        if (v.exp_err)      e = {1'b1, 1'b1, last_d};
        else if (v.we)      e = {1'b0, 1'b0, 32'h0};
        else                e = {1'b1, 1'b0, v.exp_data};
        if (!v.we && !v.exp_err) last_d = v.exp_data;
        exp_d_q.push_back(e);
        @(posedge clk); #1;
        we_cnt  = 0;
        d_req   = 1'b1;
        d_we    = v.we;
        d_addr  = v.addr;
        d_size  = v.size;
        d_sext  = v.sext;
        d_wdata = v.wdata;
        acc = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (d_ready) begin acc = 1'b1; break; end
        end
        chk("d_ready seen", {31'd0, acc}, 32'd1);
        @(posedge clk); #1;
        d_req = 1'b0;
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (d_valid) begin lat = k; break; end
        end
        chk("d_valid latency", lat, v.exp_lat);
        @(posedge clk); #1;
        chk("m_we cycles", we_cnt, (v.we && !v.exp_err) ? 1 : 0);
        if (v.we) chk("ram word", mem[v.addr[13:2]], v.exp_data);
    endtask

    task automatic do_i(input logic [13:0] addr, input logic [31:0] exp);
        logic acc;
        int   lat;
        exp_i_q.push_back(exp);
        @(posedge clk); #1;
        i_req  = 1'b1;
        i_addr = addr;
        acc = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (i_ready) begin acc = 1'b1; break; end
        end
        chk("i_ready seen", {31'd0, acc}, 32'd1);
        @(posedge clk); #1;
        i_req = 1'b0;
        lat = 99;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (i_valid) begin lat = k; break; end
        end
        chk("i_valid latency", lat, 3);
    endtask

    initial begin
        logic        exp_g;
        logic        g;
        int          ng;
        int          cyc;
        int          last_cyc;

        for (int a = 0; a < 4096; a++) mem[a] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'h80817F01;
        mem[2] = 32'h12345678;
        mem[4] = 32'hCAFEF00D;

        //            we  addr      size  sx wdata          exp_data       err lat
        vecs[0]  = '{1'b0, 14'h0005, SZ_B, 1'b1, 32'h0,        32'h0000007F, 1'b0, 3};
        vecs[1]  = '{1'b0, 14'h0007, SZ_B, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0, 3};
        vecs[2]  = '{1'b0, 14'h0007, SZ_B, 1'b0, 32'h0,        32'h00000080, 1'b0, 3};
        vecs[3]  = '{1'b0, 14'h0004, SZ_W, 1'b1, 32'h0,        32'h80817F01, 1'b0, 3};
        vecs[4]  = '{1'b1, 14'h0006, SZ_B, 1'b0, 32'h123456AB, 32'h80AB7F01, 1'b0, 4};
        vecs[5]  = '{1'b0, 14'h0006, SZ_H, 1'b1, 32'h0,        32'hFFFF80AB, 1'b0, 3};
        vecs[6]  = '{1'b0, 14'h0006, SZ_H, 1'b0, 32'h0,        32'h000080AB, 1'b0, 3};
        vecs[7]  = '{1'b0, 14'h0004, SZ_H, 1'b1, 32'h0,        32'h00007F01, 1'b0, 3};
        vecs[8]  = '{1'b0, 14'h0003, SZ_H, 1'b0, 32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{1'b1, 14'h0002, SZ_W, 1'b0, 32'hFFFFFFFF, 32'h11223344, 1'b1, 1};
        vecs[10] = '{1'b0, 14'h0008, 2'b11, 1'b0, 32'h0,       32'h0,        1'b1, 1};
        vecs[11] = '{1'b1, 14'h000A, SZ_H, 1'b0, 32'h0000BEEF, 32'hBEEF5678, 1'b0, 4};
        vecs[12] = '{1'b0, 14'h0008, SZ_W, 1'b0, 32'h0,        32'hBEEF5678, 1'b0, 3};
        vecs[13] = '{1'b1, 14'h000C, SZ_W, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2};
        vecs[14] = '{1'b0, 14'h000C, SZ_W, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 3};
        vecs[15] = '{1'b0, 14'h000C, SZ_B, 1'b0, 32'h0,        32'h000000EF, 1'b0, 3};
        vecs[16] = '{1'b1, 14'h0007, SZ_B, 1'b0, 32'h00000055, 32'h55AB7F01, 1'b0, 4};
        vecs[17] = '{1'b0, 14'h0007, SZ_B, 1'b1, 32'h0,        32'h00000055, 1'b0, 3};
        vecs[18] = '{1'b1, 14'h0010, SZ_H, 1'b0, 32'h00008001, 32'hCAFE8001, 1'b0, 4};
        vecs[19] = '{1'b0, 14'h0010, SZ_H, 1'b1, 32'h0,        32'hFFFF8001, 1'b0, 3};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        chk("rst i_valid", {31'd0, i_valid}, 32'd0);
        chk("rst d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst d_err", {31'd0, d_err}, 32'd0);
        chk("rst m_we", {31'd0, m_we}, 32'd0);
        chk("rst i_rdata", i_rdata, 32'd0);
        chk("rst d_rdata", d_rdata, 32'd0);
        chk("rst m_addr", {20'd0, m_addr}, 32'd0);
        chk("rst m_wdata", m_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // table-driven data-port accesses
        for (int v = 0; v < 20; v++) do_d(vecs[v]);

        // fetch alone; low address bits are ignored
        do_i(14'h0013, mem[4]);

        // arbitration from reset with both ports held
        @(posedge clk); #1;
        rst     = 1'b1;
        last_d  = '0;
        i_req   = 1'b1;
        i_addr  = 14'h0010;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 14'h0004;
        d_size  = SZ_W;
        d_sext  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_g    = GNT_D;
        ng       = 0;
        last_cyc = 0;
        for (cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (i_ready && d_ready) chk("single ready", 32'd1, 32'd0);
            if (i_ready || d_ready) begin
                g = d_ready;
                chk("grant order", {31'd0, g}, {31'd0, exp_g});
                if (ng > 0) chk("grant spacing", cyc - last_cyc, 3);
                if (g == GNT_D) begin
                    exp_d_q.push_back({1'b1, 1'b0, mem[1]});
                    last_d = mem[1];
                end else begin
                    exp_i_q.push_back(mem[4]);
                end
                exp_g    = ~exp_g;
                last_cyc = cyc;
                ng++;
                if (ng == 8) break;
            end
        end
        chk("grant count", ng, 8);
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("d queue drained", exp_d_q.size(), 0);
        chk("i queue drained", exp_i_q.size(), 0);

        // reset during WAIT of a byte store to word 0
        we_cnt = 0;
        dv_cnt = 0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 14'h0001;
        d_size  = SZ_B;
        d_wdata = 32'h00000099;
        begin
            logic acc;
            acc = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (d_ready) begin acc = 1'b1; break; end
            end
            chk("rmw store accepted", {31'd0, acc}, 32'd1);
        end
        @(posedge clk); #1;            // RD
        d_req = 1'b0;
        @(posedge clk); #1;            // WAIT
        chk("in WAIT", {30'd0, dbg_state}, {30'd0, ST_WAIT});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        last_d = '0;
        @(negedge clk);
        chk("idle after rst", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        repeat (5) @(posedge clk);
        #1;
        chk("no m_we after rst", we_cnt, 0);
        chk("no d_valid after rst", dv_cnt, 0);
        chk("ram word 0 kept", mem[0], 32'h11223344);

        // normal service resumes
        do_d('{1'b0, 14'h0000, SZ_W, 1'b0, 32'h0, 32'h11223344, 1'b0, 3});
        do_d('{1'b0, 14'h0003, SZ_B, 1'b0, 32'h0, 32'h00000011, 1'b0, 3});

        repeat (3) @(posedge clk);
        chk("final d queue empty", exp_d_q.size(), 0);
        chk("final i queue empty", exp_i_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, word-wide synchronous RAM between the instruction-fetch port and the load/store port of the core. Arbitrates round-robin between the two requesters and sequences each access. Byte and halfword stores are done as read-modify-write. Loads are lane-extracted and sign- or zero-extended. The block sits between the core and the RAM macro: the core sees two request/ready/valid ports and the RAM sees one address, write-enable and data bus.

Parameters:
ADDR_W, 14, byte address width; RAM word address is ADDR_W-2 bits (4096 words default)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
i_req  in  1  fetch request; held stable until i_ready
i_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
i_ready  out  1  fetch accepted this cycle (combinational)
i_valid  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  32  fetched word
d_req  in  1  data request; held stable until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
d_sext  in  1  sign-extend a sub-word load
d_wdata  in  32  store data, right-aligned
d_ready  out  1  data request accepted this cycle (combinational)
d_valid  out  1  one-cycle pulse: load data or store done
d_rdata  out  32  formatted load data
d_err  out  1  qualifies d_valid: misaligned or illegal access
m_addr  out  ADDR_W-2  RAM word address
m_we  out  1  RAM write enable
m_wdata  out  32  RAM write data
m_rdata  in  32  RAM read data, one cycle after m_addr

Behaviour:
- Reset values:
  - state IDLE, last_grant = I
  - i_valid, d_valid, d_err, m_we = 0
  - i_rdata, d_rdata, m_addr, m_wdata = 0
  - m_we is gated by !rst combinationally.
- Reset mid-operation: the in-flight access is dropped. No RAM write and no valid pulse occur. The block is in IDLE the cycle after rst deasserts.
- Arbitration happens only in IDLE.
  - One request pending: grant it.
  - Both pending: grant the port that is not last_grant.
  - Exactly one ready is asserted in the grant cycle, and the request is registered.
  - last_grant is updated on each grant.
- States: IDLE, RD, WAIT, WR.
- Fetch or load: IDLE (accept) -> RD (m_addr driven, m_we=0) -> WAIT (m_rdata formatted and registered) -> IDLE. The valid pulse occurs in the IDLE cycle, 3 cycles after accept.
- Word store: IDLE -> WR (m_we=1, m_wdata=d_wdata) -> IDLE. d_valid occurs 2 cycles after accept.
- Sub-word store: IDLE -> RD -> WAIT (merged word registered) -> WR -> IDLE. Only the addressed lanes are replaced. d_valid occurs 4 cycles after accept.
- Error accesses (no RAM access, return to IDLE):
  - Cases: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - d_valid and d_err both pulse 1 cycle after accept.
  - d_rdata is left unchanged.
- Load formatting:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Result is zero- or sign-extended per d_sext; word loads ignore d_sext.
- Back-to-back traffic: a new grant is possible in the same IDLE cycle in which the previous valid pulse occurs. Peak throughput is one read per 3 cycles.
- A new request may be issued in the same cycle as the previous valid. Requests must not change while waiting for ready.

Decomposition:
- Package mem_pkg holds:
  - size codes SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10
  - the state enum
  - grant constants GNT_I, GNT_D
- One sub-module, mem_lane_fmt, is purely combinational. It performs load extract/extend and store lane merge.
- The arbiter FSM stays in the top module.

Test Plan:
- Load extension: preload mem[1]=0x80817F01.
  - Byte load 0x0005, sext=1 -> d_rdata 0x0000007F.
  - Byte load 0x0007, sext=1 -> 0xFFFFFF80; sext=0 -> 0x00000080.
  - d_valid exactly 3 cycles after d_ready each time.
- Byte store: store 0xAB at 0x0006 over 0x80817F01 -> mem[1]=0x80AB7F01. m_we high for exactly 1 cycle; d_valid 4 cycles after accept.
- Half load: load at 0x0006 with sext=1 after the byte store above -> d_rdata 0xFFFF80AB.
- Arbitration: from reset, hold i_req (addr 0x0010) and d_req (load 0x0004) continuously. First grant goes to D, then I, D, I...; i_rdata = mem[4] on each i_valid.
- Misaligned: half load at 0x0003 -> d_valid=d_err=1 one cycle after accept, m_we never asserts, d_rdata unchanged. A word store to 0x0002 gives the same result.
- Reset mid-operation: assert rst during WAIT of a byte store -> m_we stays 0, no d_valid, mem unchanged. The next request is granted normally after rst deasserts.
